// File: rtl/z80_dma_master_pkg.sv
// rtl/z80_dma_master_pkg.sv - shared command codes, state encodings and status layout for the Z80 DMA master
package z80_dma_master_pkg;

  // Command byte codes (first byte of every frame)
  localparam logic [7:0] CMD_CLEAR = 8'h00;
  localparam logic [7:0] CMD_WRITE = 8'h01;
  localparam logic [7:0] CMD_READ  = 8'h02;

  // Bit positions inside the idle status byte returned on tx_data
  localparam int STAT_BUSY_BIT = 0;
  localparam int STAT_ERR_BIT  = 1;

  // Top-level framing / arbitration states
  typedef enum logic [3:0] {
    ST_IDLE,
    ST_H_ALO,
    ST_H_AHI,
    ST_H_LEN,
    ST_BUS_REQ,
    ST_WAIT_BYTE,
    ST_MEM_SETUP,
    ST_MEM_STROBE,
    ST_MEM_HOLD,
    ST_BUS_REL
  } dma_state_e;

  // Phases of one memory cycle inside the sequencer
  typedef enum logic [1:0] {
    PH_IDLE,
    PH_SETUP,
    PH_STROBE,
    PH_HOLD
  } cyc_phase_e;

  function automatic logic [7:0] status_byte(input logic err, input logic busy);
    logic [7:0] s;
    s = 8'h00;
    s[STAT_ERR_BIT]  = err;
    s[STAT_BUSY_BIT] = busy;
    return s;
  endfunction

  // A LEN byte of zero encodes a full 256-byte block
  function automatic logic [8:0] len_to_count(input logic [7:0] len);
    return (len == 8'h00) ? 9'd256 : {1'b0, len};
  endfunction

endpackage

// File: rtl/z80_dma_master_if.sv
// rtl/z80_dma_master_if.sv - SPI byte stream and Z80 bus signals seen by the DMA master
interface z80_dma_master_if;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [7:0]  tx_data;
  logic        busrq_n;
  logic        busack_n;
  logic [15:0] addr;
  logic        addr_oe;
  logic [7:0]  data_out;
  logic        data_oe;
  logic [7:0]  data_in;
  logic        mreq_n;
  logic        wr_n;
  logic        rd_n;
  logic        ctl_oe;
  logic        busy;
  logic        err;

  modport master (
    input  rx_data, rx_valid, busack_n, data_in,
    output tx_data, busrq_n, addr, addr_oe, data_out, data_oe,
           mreq_n, wr_n, rd_n, ctl_oe, busy, err
  );

  modport slave (
    output rx_data, rx_valid, busack_n, data_in,
    input  tx_data, busrq_n, addr, addr_oe, data_out, data_oe,
           mreq_n, wr_n, rd_n, ctl_oe, busy, err
  );
endinterface

// File: rtl/z80_mem_cycle.sv
// rtl/z80_mem_cycle.sv - one Z80 memory read or write cycle: setup, strobe low N clocks, hold
module z80_mem_cycle
  import z80_dma_master_pkg::*;
#(
  parameter int WR_LOW_CYCLES = 3,
  parameter int RD_LOW_CYCLES = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        is_write,
  input  logic [15:0] addr_in,
  input  logic [7:0]  wdata,
  input  logic [7:0]  data_in,
  output logic [15:0] addr,
  output logic [7:0]  data_out,
  output logic        mreq_n,
  output logic        wr_n,
  output logic        rd_n,
  output logic [7:0]  rdata,
  output logic        rd_sample,
  output logic        strobe_last,
  output logic        done
);

  localparam logic [7:0] WR_LAST = 8'(WR_LOW_CYCLES - 1);
  localparam logic [7:0] RD_LAST = 8'(RD_LOW_CYCLES - 1);

  cyc_phase_e  phase_q, phase_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        is_write_q, is_write_d;
  logic [15:0] addr_q, addr_d;
  logic [7:0]  wdata_q, wdata_d;
  logic [7:0]  last_cnt;

  assign last_cnt    = is_write_q ? WR_LAST : RD_LAST;
  assign strobe_last = (phase_q == PH_STROBE) && (cnt_q == last_cnt);

  // Phase sequencing; address and write data are captured at start and held to the next start
  always_comb begin
    phase_d    = phase_q;
    cnt_d      = cnt_q;
    is_write_d = is_write_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    case (phase_q)
      PH_IDLE: begin
        if (start) begin
          phase_d    = PH_SETUP;
          is_write_d = is_write;
          addr_d     = addr_in;
          if (is_write) wdata_d = wdata;
        end
      end
      PH_SETUP: begin
        phase_d = PH_STROBE;
        cnt_d   = 8'd0;
      end
      PH_STROBE: begin
        if (strobe_last) phase_d = PH_HOLD;
        else             cnt_d   = cnt_q + 8'd1;
      end
      PH_HOLD:  phase_d = PH_IDLE;
      default:  phase_d = PH_IDLE;
    endcase
  end

  // Cycle state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q    <= PH_IDLE;
      cnt_q      <= 8'd0;
      is_write_q <= 1'b0;
      addr_q     <= 16'h0000;
      wdata_q    <= 8'h00;
    end else begin
      phase_q    <= phase_d;
      cnt_q      <= cnt_d;
      is_write_q <= is_write_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
    end
  end

  assign addr      = addr_q;
  assign data_out  = wdata_q;
  assign mreq_n    = ~(phase_q == PH_STROBE);
  assign wr_n      = ~((phase_q == PH_STROBE) && is_write_q);
  assign rd_n      = ~((phase_q == PH_STROBE) && !is_write_q);
  // Read data is taken from the bus on the last low clock of rd_n
  assign rdata     = data_in;
  assign rd_sample = strobe_last && !is_write_q;
  assign done      = (phase_q == PH_HOLD);

endmodule

// File: rtl/z80_dma_master.sv
// rtl/z80_dma_master.sv - SPI-framed bus-mastering DMA engine for the Z80 memory bus
module z80_dma_master
  import z80_dma_master_pkg::*;
#(
  parameter int WR_LOW_CYCLES  = 3,
  parameter int RD_LOW_CYCLES  = 3,
  parameter int BUSACK_TIMEOUT = 4096
) (
  input logic              clk,
  input logic              rst_n,
  z80_dma_master_if.master bus
);

  localparam int              TO_W    = $clog2(BUSACK_TIMEOUT) + 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(BUSACK_TIMEOUT - 1);

  dma_state_e      state_q, state_d;
  logic            err_q, err_d;
  logic            is_write_q, is_write_d;
  logic [15:0]     ptr_q, ptr_d;
  logic [8:0]      cnt_q, cnt_d;
  logic [TO_W-1:0] to_q, to_d;
  logic [7:0]      tx_q, tx_d;
  logic [1:0]      ack_sync_q, ack_sync_d;

  logic            cyc_start;
  logic            cyc_last;
  logic            cyc_sample;
  logic            cyc_done;
  logic [7:0]      cyc_rdata;
  logic            bus_granted;
  logic            in_mem;
  logic            bus_owned;

  // Two-flop synchroniser for the asynchronous BUSACK_n input
  always_comb ack_sync_d = {ack_sync_q[0], bus.busack_n};
  assign bus_granted = ~ack_sync_q[1];

  assign in_mem    = state_q inside {ST_MEM_SETUP, ST_MEM_STROBE, ST_MEM_HOLD};
  assign bus_owned = state_q inside {ST_WAIT_BYTE, ST_MEM_SETUP, ST_MEM_STROBE, ST_MEM_HOLD};

  // Framing, counting and arbitration; each started cycle consumes one count slot and one address
  always_comb begin
    state_d    = state_q;
    err_d      = err_q;
    is_write_d = is_write_q;
    ptr_d      = ptr_q;
    cnt_d      = cnt_q;
    to_d       = to_q;
    tx_d       = tx_q;
    cyc_start  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.rx_valid) begin
          case (bus.rx_data)
            CMD_CLEAR: err_d = 1'b0;
            CMD_WRITE: begin
              is_write_d = 1'b1;
              state_d    = ST_H_ALO;
            end
            CMD_READ: begin
              is_write_d = 1'b0;
              state_d    = ST_H_ALO;
            end
            default:   err_d = 1'b1;
          endcase
        end
      end
      ST_H_ALO: begin
        if (bus.rx_valid) begin
          ptr_d[7:0] = bus.rx_data;
          state_d    = ST_H_AHI;
        end
      end
      ST_H_AHI: begin
        if (bus.rx_valid) begin
          ptr_d[15:8] = bus.rx_data;
          state_d     = ST_H_LEN;
        end
      end
      ST_H_LEN: begin
        if (bus.rx_valid) begin
          cnt_d   = len_to_count(bus.rx_data);
          to_d    = '0;
          state_d = ST_BUS_REQ;
        end
      end
      ST_BUS_REQ: begin
        if (bus_granted) begin
          if (is_write_q) begin
            state_d = ST_WAIT_BYTE;
          end else begin
            // Reads fetch the first byte immediately so it is ready for the next SPI transfer
            cyc_start = 1'b1;
            cnt_d     = cnt_q - 9'd1;
            ptr_d     = ptr_q + 16'd1;
            state_d   = ST_MEM_SETUP;
          end
        end else if (to_q == TO_LAST) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          to_d = to_q + TO_W'(1);
        end
      end
      ST_WAIT_BYTE: begin
        if (bus.rx_valid) begin
          if (cnt_q == 9'd0) begin
            // Only reachable on reads: the byte clocked in while the last read byte went out
            state_d = ST_BUS_REL;
          end else begin
            cyc_start = 1'b1;
            cnt_d     = cnt_q - 9'd1;
            ptr_d     = ptr_q + 16'd1;
            state_d   = ST_MEM_SETUP;
          end
        end
      end
      ST_MEM_SETUP:  state_d = ST_MEM_STROBE;
      ST_MEM_STROBE: begin
        if (cyc_sample) tx_d = cyc_rdata;
        if (cyc_last)   state_d = ST_MEM_HOLD;
      end
      ST_MEM_HOLD: begin
        if (cyc_done) state_d = (is_write_q && cnt_q == 9'd0) ? ST_BUS_REL : ST_WAIT_BYTE;
      end
      ST_BUS_REL: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase

    // Overrun: the byte is dropped but still occupies its slot, so later bytes keep their addresses
    if (in_mem && bus.rx_valid) begin
      err_d = 1'b1;
      if (cnt_q != 9'd0) begin
        cnt_d = cnt_q - 9'd1;
        ptr_d = ptr_q + 16'd1;
      end
    end
  end

  // State register; asynchronous reset releases the bus at once
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      err_q      <= 1'b0;
      is_write_q <= 1'b0;
      ptr_q      <= 16'h0000;
      cnt_q      <= 9'd0;
      to_q       <= '0;
      tx_q       <= 8'h00;
      ack_sync_q <= 2'b11;
    end else begin
      state_q    <= state_d;
      err_q      <= err_d;
      is_write_q <= is_write_d;
      ptr_q      <= ptr_d;
      cnt_q      <= cnt_d;
      to_q       <= to_d;
      tx_q       <= tx_d;
      ack_sync_q <= ack_sync_d;
    end
  end

  z80_mem_cycle #(
    .WR_LOW_CYCLES (WR_LOW_CYCLES),
    .RD_LOW_CYCLES (RD_LOW_CYCLES)
  ) u_cycle (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (cyc_start),
    .is_write    (is_write_q),
    .addr_in     (ptr_q),
    .wdata       (bus.rx_data),
    .data_in     (bus.data_in),
    .addr        (bus.addr),
    .data_out    (bus.data_out),
    .mreq_n      (bus.mreq_n),
    .wr_n        (bus.wr_n),
    .rd_n        (bus.rd_n),
    .rdata       (cyc_rdata),
    .rd_sample   (cyc_sample),
    .strobe_last (cyc_last),
    .done        (cyc_done)
  );

  // BUSRQ_n stays low through BUS_REL so the drivers are off one clock before the bus is returned
  assign bus.busrq_n = ~(bus_owned || state_q == ST_BUS_REQ || state_q == ST_BUS_REL);
  assign bus.ctl_oe  = bus_owned;
  assign bus.addr_oe = bus_owned;
  assign bus.data_oe = bus_owned && is_write_q;
  assign bus.busy    = (state_q != ST_IDLE);
  assign bus.err     = err_q;
  assign bus.tx_data = (state_q == ST_IDLE) ? status_byte(err_q, state_q != ST_IDLE) : tx_q;

endmodule
